// File: rtl/path_replayer.sv
// Walks the solved direction stack and emits one move per valid/ready handshake,
// tracking the resulting grid position. Define REPLAY_REVERSE_EN to add goal-to-start playback.
module path_replayer #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned PTR_W     = 8,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
`ifdef REPLAY_REVERSE_EN
  input  logic               reverse,
`endif
  input  logic [2*DEPTH-1:0] stack_flat,
  input  logic [PTR_W-1:0]   top,
  output logic [1:0]         move_dir,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  localparam logic [COORD_W-1:0] CoordMax = '1;
  localparam logic [COORD_W-1:0] RowInit  = COORD_W'(START_ROW);
  localparam logic [COORD_W-1:0] ColInit  = COORD_W'(START_COL);

  state_e             state_q, state_d;
  logic [1:0]         move_dir_q, move_dir_d;
  logic               move_valid_q, move_valid_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [PTR_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic               reverse_q, reverse_d;

  logic               rev_in;
  logic [PTR_W-1:0]   idx_next, fetch_idx;
  logic [1:0]         entry_raw, entry_dir;
  logic [COORD_W-1:0] row_mv, col_mv;
  logic               edge_hit, accept, last;

`ifdef REPLAY_REVERSE_EN
  assign rev_in = reverse;
`else
  assign rev_in = 1'b0;
`endif

  // Fetch path: in IDLE it selects the first entry to present, otherwise the following one.
  assign idx_next  = reverse_q ? (idx_q - PTR_W'(1)) : (idx_q + PTR_W'(1));
  assign fetch_idx = (state_q == StIdle) ? (rev_in ? (top - PTR_W'(1)) : '0) : idx_next;
  assign entry_raw = stack_flat[{fetch_idx, 1'b0} +: 2];
  assign entry_dir = ((state_q == StIdle) ? rev_in : reverse_q) ? ~entry_raw : entry_raw;

  assign accept = move_valid_q && move_ready;
  assign last   = reverse_q ? (idx_q == '0) : (idx_q == (len_q - PTR_W'(1)));

  // Saturating position update for the move currently presented.
  always_comb begin
    row_mv   = row_q;
    col_mv   = col_q;
    edge_hit = 1'b0;
    unique case (move_dir_q)
      2'b00: if (row_q == '0)      edge_hit = 1'b1; else row_mv = row_q - COORD_W'(1);
      2'b01: if (col_q == CoordMax) edge_hit = 1'b1; else col_mv = col_q + COORD_W'(1);
      2'b10: if (col_q == '0)      edge_hit = 1'b1; else col_mv = col_q - COORD_W'(1);
      2'b11: if (row_q == CoordMax) edge_hit = 1'b1; else row_mv = row_q + COORD_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    move_dir_d   = move_dir_q;
    move_valid_d = move_valid_q;
    row_d        = row_q;
    col_d        = col_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    len_d        = len_q;
    idx_d        = idx_q;
    reverse_d    = reverse_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          if (top != '0) begin
            state_d      = StPlay;
            len_d        = top;
            idx_d        = fetch_idx;
            reverse_d    = rev_in;
            move_dir_d   = entry_dir;
            move_valid_d = 1'b1;
            busy_d       = 1'b1;
            // Reverse playback continues from wherever the forward walk ended.
            if (!rev_in) begin
              row_d = RowInit;
              col_d = ColInit;
            end
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StPlay: begin
        if (accept) begin
          row_d   = row_mv;
          col_d   = col_mv;
          error_d = error_q | edge_hit;
          if (last) begin
            state_d      = StDone;
            move_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            idx_d      = idx_next;
            move_dir_d = entry_dir;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      move_dir_q   <= 2'b00;
      move_valid_q <= 1'b0;
      row_q        <= RowInit;
      col_q        <= ColInit;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      reverse_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_dir_q   <= move_dir_d;
      move_valid_q <= move_valid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      reverse_q    <= reverse_d;
    end
  end

  assign move_dir   = move_dir_q;
  assign move_valid = move_valid_q;
  assign row        = row_q;
  assign col        = col_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
